// File: rtl/archie_kbd.sv
// Archimedes keyboard microcontroller emulation: handshake, ID, LEDs, key and
// mouse packets with BACK/SACK/MACK/SMAK/NACK flow control toward the IOC.
module archie_kbd #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] KBD_ID     = 8'h81
) (
  input  logic              clkcpu,
  input  logic              rst_i,
  input  logic [7:0]        kbd_out_data,
  input  logic              kbd_out_strobe,
  output logic [7:0]        kbd_in_data,
  output logic              kbd_in_strobe,
  input  logic [7:0]        key_code,
  input  logic              key_down,
  input  logic              key_strobe,
  input  logic signed [7:0] mouse_dx,
  input  logic signed [7:0] mouse_dy,
  input  logic              mouse_strobe,
  output logic [2:0]        leds
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_RST_TX, S_WAIT_RAK1, S_WAIT_RAK2, S_IDLE, S_WAIT_BACK, S_WAIT_ACK
  } state_t;

  function automatic logic signed [9:0] sat10(input logic signed [10:0] v);
    if (v > 11'sd511)       return 10'sd511;
    else if (v < -11'sd511) return -10'sd511;
    else                    return v[9:0];
  endfunction

  function automatic logic signed [6:0] clamp7(input logic signed [9:0] v);
    if (v > 10'sd63)       return 7'sd63;
    else if (v < -10'sd64) return 7'b100_0000;
    else                   return v[6:0];
  endfunction

  state_t             r_state, w_next_state;
  logic               r_in_strobe, w_tx;
  logic [7:0]         r_in_data, w_tx_data;
  logic [7:0]         r_second, w_second_nx;
  logic [2:0]         r_leds, w_leds_nx;
  logic               r_key_en, r_mouse_en, w_key_en_nx, w_mouse_en_nx;
  logic               w_pop, w_push, w_flush, w_mouse_sub;
  logic               w_launch_key, w_launch_mouse, w_is_ack;
  logic [8:0]         r_fifo [FIFO_DEPTH];
  logic [AW:0]        r_wr_ptr, r_rd_ptr;
  logic               w_empty, w_full;
  logic [8:0]         w_head;
  logic [7:0]         w_key_pfx;
  logic signed [9:0]  r_acc_x, r_acc_y;
  logic signed [6:0]  w_send_x, w_send_y;
  logic signed [10:0] w_sum_x, w_sum_y;

  assign kbd_in_data   = r_in_data;
  assign kbd_in_strobe = r_in_strobe;
  assign leds          = r_leds;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head    = r_fifo[r_rd_ptr[AW-1:0]];
  assign w_key_pfx = w_head[8] ? 8'hC0 : 8'hD0;
  assign w_is_ack  = (kbd_out_data[7:2] == 6'b0011_00);
  assign w_send_x  = clamp7(r_acc_x);
  assign w_send_y  = clamp7(r_acc_y);
  // A full FIFO still accepts a push when the head is leaving this cycle.
  assign w_push    = key_strobe && (!w_full || w_pop) && !w_flush;

  always_comb begin
    w_next_state   = r_state;
    w_tx           = 1'b0;
    w_tx_data      = 8'h00;
    w_second_nx    = r_second;
    w_leds_nx      = r_leds;
    w_key_en_nx    = r_key_en;
    w_mouse_en_nx  = r_mouse_en;
    w_pop          = 1'b0;
    w_flush        = 1'b0;
    w_mouse_sub    = 1'b0;
    w_launch_key   = 1'b0;
    w_launch_mouse = 1'b0;
    if (kbd_out_strobe && kbd_out_data == 8'hFF) begin
      w_flush       = 1'b1;
      w_key_en_nx   = 1'b0;
      w_mouse_en_nx = 1'b0;
      w_next_state  = S_RST_TX;
    end else begin
      case (r_state)
        S_RST_TX: begin
          w_tx         = 1'b1;
          w_tx_data    = 8'hFF;
          w_next_state = S_WAIT_RAK1;
        end
        S_WAIT_RAK1: if (kbd_out_strobe) begin
          if (kbd_out_data == 8'hFE) begin
            w_tx         = 1'b1;
            w_tx_data    = 8'hFE;
            w_next_state = S_WAIT_RAK2;
          end else w_next_state = S_RST_TX;
        end
        S_WAIT_RAK2: if (kbd_out_strobe) begin
          if (kbd_out_data == 8'hFD) begin
            w_tx          = 1'b1;
            w_tx_data     = 8'hFD;
            w_key_en_nx   = 1'b0;
            w_mouse_en_nx = 1'b0;
            w_next_state  = S_IDLE;
          end else w_next_state = S_RST_TX;
        end
        S_IDLE: begin
          if (kbd_out_strobe) begin
            if (kbd_out_data[7:3] == 5'b0) w_leds_nx = kbd_out_data[2:0];
            else if (w_is_ack) begin
              w_key_en_nx   = kbd_out_data[0];
              w_mouse_en_nx = kbd_out_data[1];
            end else if (kbd_out_data == 8'h20) begin
              w_tx      = 1'b1;
              w_tx_data = KBD_ID;
            end else if (kbd_out_data == 8'h22) w_launch_mouse = 1'b1;
          end else if (!r_in_strobe) begin
            // Keys win over mouse; never emit on back-to-back cycles.
            if (r_key_en && !w_empty) w_launch_key = 1'b1;
            else if (r_mouse_en && (r_acc_x != 10'sd0 || r_acc_y != 10'sd0))
              w_launch_mouse = 1'b1;
          end
        end
        S_WAIT_BACK: if (kbd_out_strobe) begin
          if (kbd_out_data == 8'h3F) begin
            w_tx         = 1'b1;
            w_tx_data    = r_second;
            w_next_state = S_WAIT_ACK;
          end else if (w_is_ack) begin
            w_key_en_nx   = kbd_out_data[0];
            w_mouse_en_nx = kbd_out_data[1];
            w_next_state  = S_IDLE;
          end
        end
        S_WAIT_ACK: if (kbd_out_strobe && w_is_ack) begin
          w_key_en_nx   = kbd_out_data[0];
          w_mouse_en_nx = kbd_out_data[1];
          w_next_state  = S_IDLE;
        end
        default: w_next_state = S_RST_TX;
      endcase
    end
    if (w_launch_key) begin
      w_pop         = 1'b1;
      w_tx          = 1'b1;
      w_tx_data     = w_key_pfx | {4'h0, w_head[7:4]};
      w_second_nx   = w_key_pfx | {4'h0, w_head[3:0]};
      w_key_en_nx   = 1'b0;
      w_mouse_en_nx = 1'b0;
      w_next_state  = S_WAIT_BACK;
    end
    if (w_launch_mouse) begin
      w_mouse_sub   = 1'b1;
      w_tx          = 1'b1;
      w_tx_data     = {1'b0, w_send_x};
      w_second_nx   = {1'b0, w_send_y};
      w_key_en_nx   = 1'b0;
      w_mouse_en_nx = 1'b0;
      w_next_state  = S_WAIT_BACK;
    end
  end

  // The sent amount and a coincident new delta fold into one update.
  always_comb begin
    w_sum_x = {r_acc_x[9], r_acc_x}
            - (w_mouse_sub  ? {{4{w_send_x[6]}}, w_send_x} : 11'd0)
            + (mouse_strobe ? {{3{mouse_dx[7]}}, mouse_dx} : 11'd0);
    w_sum_y = {r_acc_y[9], r_acc_y}
            - (w_mouse_sub  ? {{4{w_send_y[6]}}, w_send_y} : 11'd0)
            + (mouse_strobe ? {{3{mouse_dy[7]}}, mouse_dy} : 11'd0);
  end

  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      r_state     <= S_RST_TX;
      r_in_strobe <= 1'b0;
      r_in_data   <= 8'h00;
      r_leds      <= 3'b000;
      r_key_en    <= 1'b0;
      r_mouse_en  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_in_strobe <= w_tx;
      r_in_data   <= w_tx ? w_tx_data : r_in_data;
      r_leds      <= w_leds_nx;
      r_key_en    <= w_key_en_nx;
      r_mouse_en  <= w_mouse_en_nx;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_acc_x  <= '0;
        r_acc_y  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_acc_x <= sat10(w_sum_x);
        r_acc_y <= sat10(w_sum_y);
      end
    end
  end

  always_ff @(posedge clkcpu) begin
    r_second <= w_second_nx;
    if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= {key_down, key_code};
  end

endmodule

// File: tb/tb_archie_kbd.sv
// Directed bench for archie_kbd: handshake, commands, key and mouse packets,
// flow control, FIFO overflow and HRST flushing.
module tb_archie_kbd;

  logic        clkcpu = 1'b0;
  logic        rst_i;
  logic [7:0]  kbd_out_data;
  logic        kbd_out_strobe;
  logic [7:0]  kbd_in_data;
  logic        kbd_in_strobe;
  logic [7:0]  key_code;
  logic        key_down;
  logic        key_strobe;
  logic signed [7:0] mouse_dx, mouse_dy;
  logic        mouse_strobe;
  logic [2:0]  leds;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clkcpu = ~clkcpu;

  archie_kbd #(.FIFO_DEPTH(4), .KBD_ID(8'h81)) dut (
    .clkcpu(clkcpu), .rst_i(rst_i),
    .kbd_out_data(kbd_out_data), .kbd_out_strobe(kbd_out_strobe),
    .kbd_in_data(kbd_in_data), .kbd_in_strobe(kbd_in_strobe),
    .key_code(key_code), .key_down(key_down), .key_strobe(key_strobe),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_strobe(mouse_strobe),
    .leds(leds)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkcpu);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    kbd_out_data   = b;
    kbd_out_strobe = 1'b1;
    tick();
    kbd_out_strobe = 1'b0;
  endtask

  task automatic key_event(input logic [7:0] code, input logic down);
    key_code   = code;
    key_down   = down;
    key_strobe = 1'b1;
    tick();
    key_strobe = 1'b0;
  endtask

  task automatic mouse_event(input logic [7:0] dx, input logic [7:0] dy);
    mouse_dx     = dx;
    mouse_dy     = dy;
    mouse_strobe = 1'b1;
    tick();
    mouse_strobe = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (kbd_in_strobe) got = 1'b1;
      else tick();
    end
    if (got) begin
      check_eq(tag, {24'h0, kbd_in_data}, {24'h0, exp});
      tick();
    end else check_eq({tag, "_timeout"}, 32'hDEAD, {24'h0, exp});
  endtask

  task automatic expect_none(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (kbd_in_strobe) seen++;
      tick();
    end
    check_eq(tag, seen, 0);
  endtask

  initial begin
    rst_i = 1'b1; kbd_out_data = 8'h00; kbd_out_strobe = 1'b0;
    key_code = 8'h00; key_down = 1'b0; key_strobe = 1'b0;
    mouse_dx = 8'h00; mouse_dy = 8'h00; mouse_strobe = 1'b0;
    repeat (3) tick();
    check_eq("rst_strobe", {31'h0, kbd_in_strobe}, 0);
    check_eq("rst_data", {24'h0, kbd_in_data}, 0);
    check_eq("rst_leds", {29'h0, leds}, 0);
    rst_i = 1'b0;
    expect_byte("first_ff", 8'hFF);

    // Handshake error then proper handshake
    send_cmd(8'h20);
    expect_byte("rak1_err_ff", 8'hFF);
    send_cmd(8'hFE);
    expect_byte("rak1_fe", 8'hFE);
    send_cmd(8'hFD);
    expect_byte("rak2_fd", 8'hFD);
    expect_none("idle_quiet", 10);

    // Plain commands
    send_cmd(8'h20);
    expect_byte("rqid", 8'h81);
    send_cmd(8'h05);
    check_eq("leds_05", {29'h0, leds}, 3'b101);
    send_cmd(8'h7A);
    expect_none("unknown_7a", 6);

    // Key down/up packets
    key_event(8'h3A, 1'b1);
    expect_none("key_disabled", 4);
    send_cmd(8'h31);
    expect_byte("kdda_row", 8'hC3);
    send_cmd(8'h3F);
    expect_byte("kdda_col", 8'hCA);
    send_cmd(8'h31);
    key_event(8'h3A, 1'b0);
    expect_byte("kuda_row", 8'hD3);
    send_cmd(8'h3F);
    expect_byte("kuda_col", 8'hDA);
    send_cmd(8'h30);

    // Five events into a 4-deep FIFO: the fifth is dropped
    key_event(8'h11, 1'b1);
    key_event(8'h22, 1'b1);
    key_event(8'h33, 1'b1);
    key_event(8'h44, 1'b1);
    key_event(8'h55, 1'b1);
    send_cmd(8'h31);
    expect_byte("fifo1_row", 8'hC1);
    send_cmd(8'h3F);
    expect_byte("fifo1_col", 8'hC1);
    send_cmd(8'h31);
    expect_byte("fifo2_row", 8'hC2);
    send_cmd(8'h3F);
    expect_byte("fifo2_col", 8'hC2);
    send_cmd(8'h31);
    expect_byte("fifo3_row", 8'hC3);
    send_cmd(8'h3F);
    expect_byte("fifo3_col", 8'hC3);
    send_cmd(8'h31);
    expect_byte("fifo4_row", 8'hC4);
    send_cmd(8'h3F);
    expect_byte("fifo4_col", 8'hC4);
    send_cmd(8'h31);
    expect_none("fifo5_dropped", 8);

    // Mouse clamp and residual
    mouse_event(8'd100, 8'hFD);
    expect_none("mouse_disabled", 4);
    send_cmd(8'h33);
    expect_byte("mouse_dx63", 8'h3F);
    send_cmd(8'h3F);
    expect_byte("mouse_dym3", 8'h7D);
    send_cmd(8'h30);
    expect_none("mouse_nack_quiet", 4);
    send_cmd(8'h33);
    expect_byte("mouse_resid_dx", 8'h25);
    send_cmd(8'h3F);
    expect_byte("mouse_resid_dy", 8'h00);
    send_cmd(8'h33);
    expect_none("mouse_drained", 6);

    // RQMP sends regardless of enables, negative clamp
    send_cmd(8'h30);
    mouse_event(8'h9C, 8'd5);
    expect_none("rqmp_wait", 3);
    send_cmd(8'h22);
    expect_byte("rqmp_dx", 8'h40);
    send_cmd(8'h3F);
    expect_byte("rqmp_dy", 8'h05);
    send_cmd(8'h30);

    // Abandon a key packet with SACK instead of BACK
    key_event(8'h21, 1'b1);
    send_cmd(8'h31);
    expect_byte("abandon_row", 8'hC2);
    send_cmd(8'h31);
    expect_none("abandon_no_col", 5);
    key_event(8'h45, 1'b0);
    expect_byte("after_abandon_row", 8'hD4);
    send_cmd(8'h3F);
    expect_byte("after_abandon_col", 8'hD5);

    // HRST in WAIT_ACK flushes the FIFO and the mouse residual (-36)
    key_event(8'h66, 1'b1);
    send_cmd(8'hFF);
    expect_byte("hrst_ff", 8'hFF);
    send_cmd(8'hFE);
    expect_byte("hrst_fe", 8'hFE);
    send_cmd(8'hFD);
    expect_byte("hrst_fd", 8'hFD);
    send_cmd(8'h33);
    expect_none("hrst_flushed", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/archie_kbd.md
# archie_kbd

Archimedes keyboard-protocol engine sitting directly upstream of the IOC keyboard serial port: it consumes command bytes the IOC transmits (`kbd_out_data`/`kbd_out_strobe`) and produces reply bytes into the IOC receive path (`kbd_in_data`/`kbd_in_strobe`). It emulates the A-series keyboard microcontroller: reset handshake, ID request, LED control, key up/down reporting and mouse reporting with the BACK/SACK/MACK/SMAK/NACK flow control. Host-side key and mouse events arrive as single-cycle strobes from the platform's PS/2 or USB translation logic.

## Interface
- `FIFO_DEPTH`, 4: key event FIFO entries (power of two).
- `KBD_ID`, 8'h81: byte returned for RQID.
- `clkcpu`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `kbd_out_data`  in  8  command byte from IOC.
- `kbd_out_strobe`  in  1  one-cycle pulse, `kbd_out_data` valid.
- `kbd_in_data`  out  8  reply byte to IOC.
- `kbd_in_strobe`  out  1  one-cycle pulse, `kbd_in_data` valid.
- `key_code`  in  8  [7:4] row, [3:0] column of Archimedes matrix key.
- `key_down`  in  1  1 = press, 0 = release.
- `key_strobe`  in  1  one-cycle pulse, key event valid.
- `mouse_dx`, `mouse_dy`  in  8  signed two's-complement deltas.
- `mouse_strobe`  in  1  one-cycle pulse, deltas valid.
- `leds`  out  3  LED state from last LEDS command (caps, num, scroll).

## Operation
- Command codes: HRST FF, RAK1 FE, RAK2 FD, RQID 20, PRST 21, RQMP 22, NACK 30, SACK 31, MACK 32, SMAK 33, BACK 3F, LEDS 00–07.
- Reply codes: KDDA = C0|nibble, KUDA = D0|nibble, mouse bytes = 7-bit signed in [6:0], bit 7 = 0.
- States: RST_TX, WAIT_RAK1, WAIT_RAK2, IDLE, WAIT_BACK, WAIT_ACK.
- RST_TX: send FF, go WAIT_RAK1. WAIT_RAK1: RAK1 → send FE, WAIT_RAK2; other byte → RST_TX. WAIT_RAK2: RAK2 → send FD, IDLE with key_en = mouse_en = 0; other byte → RST_TX.
- HRST received in any state: flush key FIFO, zero mouse accumulators, clear enables, go RST_TX.
- IDLE commands: RQID → send `KBID`; LEDS → `leds` ← data[2:0]; RQMP → send mouse packet without waiting for enables; NACK/SACK/MACK/SMAK → set key_en = data[0], mouse_en = data[1]; PRST, BACK, unknown → ignored.
- IDLE event launch (no command this cycle): key_en and FIFO non-empty → pop, send prefix|row, WAIT_BACK; else mouse_en and accumulator non-zero → send dx byte, WAIT_BACK. Keys have priority.
- Launching a packet clears key_en and mouse_en; the closing ack re-arms them.
- WAIT_BACK: BACK → send second byte (prefix|column, or dy byte), WAIT_ACK. NACK/SACK/MACK/SMAK → packet abandoned, enables updated, IDLE. HRST → reset path. Others ignored.
- WAIT_ACK: NACK/SACK/MACK/SMAK → enables updated, IDLE. Others ignored except HRST.
- Key FIFO: push on `key_strobe` storing {key_down, key_code}; push when full drops the new event. Push and pop in same cycle legal.
- Mouse: two 10-bit signed accumulators, sign-extended add on `mouse_strobe`, saturating at ±511. Sending clamps each axis to [−64, +63] and subtracts the sent value the same cycle; a strobe coincident with the subtract is included (acc ← acc − sent + delta).

## Timing
- Reset values: `kbd_in_strobe` 0, `kbd_in_data` 00, `leds` 000, FIFO empty, accumulators 0, enables 0, state RST_TX.
- First FF emitted on the first cycle after `rst_i` deasserts.
- Command-to-reply latency: exactly one cycle (command sampled edge N, `kbd_in_strobe` high edge N+1).
- At most one reply byte per cycle; `kbd_in_strobe` never high on consecutive cycles (IOC serializes at 31.25 kbit/s upstream of this block).
- Event launch from IDLE: one cycle after enables set or FIFO becomes non-empty.
- `leds` and enable updates take effect the cycle after the command strobe.

## Test plan
- Reset release → FF; drive FE → FE; drive FD → FD; state IDLE, no further output.
- Handshake error: in WAIT_RAK1 drive 20 → FF re-sent; later HRST during WAIT_ACK → FF, FIFO flushed.
- RQID → 81; LEDS 05 → `leds`=101; unknown 7A → no reply.
- Key 0x3A down, then SACK → C3; BACK → CA; SACK → next event eligible; release → D3/DA; five events with DEPTH 4 → fifth dropped.
- SMAK, mouse dx=+100, dy=−3 → bytes 3F (63) then BACK → 7D (−3); residual dx 37 sent after next SMAK.
- Abandon: key packet first byte, reply SACK instead of BACK → no second byte, IDLE, key_en=1, next key launches.
